fifo_tx: RTL and testbench

//  Store-and-forward Ethernet TX frame FIFO. It is the transmit-direction counterpart of the RX frame buffer.
//  It accepts 32-bit AXI-Stream frames from the user side and holds each one until its tlast is stored.
//  It then streams each complete frame to the MAC TX encoder/CRC inserter without gaps.

---
 rtl/fifo_tx.sv | 212 +++++++++++++++++++++
 tb/tb_fifo_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx.sv
// rtl/fifo_tx.sv - store-and-forward Ethernet TX frame FIFO
//
// Purpose: buffers complete 32-bit AXI-Stream frames from the user side and
// forwards each one to the MAC TX path without gaps once its tlast is stored.
// Frames longer than MAX_FRAME_WORDS are discarded whole.
//
// Ports:
//   aclk, areset            clock; synchronous active-high reset
//   s_axis_t*               user-side frame input (tdata/tkeep/tvalid/tlast/tready)
//   m_axis_t*               MAC-side frame output (tdata/tkeep/tvalid/tlast/tready)
//   frame_drop              1-cycle pulse when an oversized frame is discarded
//   frame_count             committed frames not yet fully sent
//
// Optional feature: define FIFO_TX_PAD_EN to pad frames shorter than 15 words
// with zero words (tkeep=4'hF) up to 15 words.
module fifo_tx #(
  parameter int DATA_DEPTH      = 1024,
  parameter int FRAME_SLOTS     = 8,
  parameter int MAX_FRAME_WORDS = 380
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [31:0]                  s_axis_tdata,
  input  logic [3:0]                   s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [31:0]                  m_axis_tdata,
  output logic [3:0]                   m_axis_tkeep,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic                         frame_drop,
  output logic [$clog2(FRAME_SLOTS):0] frame_count
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int SW = $clog2(FRAME_SLOTS);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_DATA   = 2'd1;
  localparam logic [1:0] W_DROP   = 2'd2;
  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_LOAD   = 2'd1;
  localparam logic [1:0] R_STREAM = 2'd2;
`ifdef FIFO_TX_PAD_EN
  localparam logic [1:0] R_PAD    = 2'd3;
  localparam int         MIN_WORDS = 15;
`endif

  logic [35:0]   mem       [DATA_DEPTH];
  logic [AW-1:0] desc_end  [FRAME_SLOTS];
  logic [3:0]    desc_keep [FRAME_SLOTS];

  logic [1:0]    w_state, r_state;
  logic [AW-1:0] wr_ptr, frame_start, rd_ptr, rd_start;
  logic [AW:0]   wcount, free_words;
  logic [SW-1:0] desc_wr, desc_rd;

  logic          desc_full, s_hs, at_limit, wr_store, commit, drop_done;
  logic          m_hs, pop, rd_is_end, load;
  logic [AW-1:0] cur_end, reclaim;
  logic [3:0]    cur_keep;
  logic          data_done;

  assign desc_full     = (frame_count == (SW+1)'(FRAME_SLOTS));
  assign s_axis_tready = !areset && ((w_state == W_DROP) || (!desc_full && free_words != '0));
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  // The word counter parks at the limit while dropping, so at_limit is
  // also true for every beat of a frame already being discarded.
  assign at_limit      = (wcount == (AW+1)'(MAX_FRAME_WORDS));
  assign wr_store      = s_hs && (w_state != W_DROP) && !at_limit;
  assign commit        = wr_store && s_axis_tlast;
  assign drop_done     = s_hs && s_axis_tlast && !wr_store;

  assign m_hs      = m_axis_tvalid && m_axis_tready;
  assign pop       = m_hs && m_axis_tlast;
  assign cur_end   = desc_end[desc_rd];
  assign cur_keep  = desc_keep[desc_rd];
  assign reclaim   = pop ? (cur_end - rd_start) : '0;
  assign rd_is_end = ((rd_ptr + AW'(1)) == cur_end);
  assign load      = (r_state == R_LOAD) ||
                     ((r_state == R_STREAM) && m_hs && !m_axis_tlast && !data_done);

`ifdef FIFO_TX_PAD_EN
  logic [AW:0] beat_n;
  logic        pad_next, short_end;
  assign pad_next  = m_hs && !m_axis_tlast &&
                     ((r_state == R_PAD) || ((r_state == R_STREAM) && data_done));
  assign short_end = rd_is_end && (beat_n < (AW+1)'(MIN_WORDS - 1));

  function automatic logic [31:0] keep_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction
`else
  assign data_done = 1'b0;
`endif

  // Frame storage and descriptor slots carry no reset; validity is held by pointers.
  always_ff @(posedge aclk) begin
    if (wr_store) mem[wr_ptr] <= {s_axis_tkeep, s_axis_tdata};
    if (commit) begin
      desc_end[desc_wr]  <= wr_ptr + AW'(1);
      desc_keep[desc_wr] <= s_axis_tkeep;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state     <= W_IDLE;
      wr_ptr      <= '0;
      frame_start <= '0;
      wcount      <= '0;
      desc_wr     <= '0;
      frame_drop  <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      if (wr_store) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (s_axis_tlast) begin
          frame_start <= wr_ptr + AW'(1);
          wcount      <= '0;
          desc_wr     <= desc_wr + SW'(1);
          w_state     <= W_IDLE;
        end else begin
          wcount  <= wcount + (AW+1)'(1);
          w_state <= W_DATA;
        end
      end else if (s_hs) begin
        if (s_axis_tlast) begin
          wr_ptr     <= frame_start;
          wcount     <= '0;
          frame_drop <= 1'b1;
          w_state    <= W_IDLE;
        end else begin
          w_state <= W_DROP;
        end
      end
    end
  end

  // Shared occupancy counters: writes, reclaims and drop rewinds may all land in one cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_count <= '0;
      free_words  <= (AW+1)'(DATA_DEPTH);
    end else begin
      frame_count <= frame_count + (SW+1)'(commit) - (SW+1)'(pop);
      free_words  <= free_words - (AW+1)'(wr_store) + (AW+1)'(reclaim) +
                     (drop_done ? wcount : '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= R_IDLE;
      rd_ptr        <= '0;
      rd_start      <= '0;
      desc_rd       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
`ifdef FIFO_TX_PAD_EN
      beat_n        <= '0;
      data_done     <= 1'b0;
`endif
    end else begin
      case (r_state)
        R_IDLE:  if (frame_count != '0) r_state <= R_LOAD;
        R_LOAD:  r_state <= R_STREAM;
        default: ;
      endcase
      // The output register is the read port: each load fetches the next word.
      if (load) begin
        rd_ptr        <= rd_ptr + AW'(1);
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= mem[rd_ptr][31:0];
        m_axis_tkeep  <= rd_is_end ? cur_keep : mem[rd_ptr][35:32];
        m_axis_tlast  <= rd_is_end;
`ifdef FIFO_TX_PAD_EN
        beat_n <= beat_n + (AW+1)'(1);
        if (short_end) begin
          m_axis_tdata <= mem[rd_ptr][31:0] & keep_mask(cur_keep);
          m_axis_tkeep <= 4'hF;
          m_axis_tlast <= 1'b0;
          data_done    <= 1'b1;
        end
`endif
      end
`ifdef FIFO_TX_PAD_EN
      if (pad_next) begin
        r_state      <= R_PAD;
        m_axis_tdata <= '0;
        m_axis_tkeep <= 4'hF;
        m_axis_tlast <= (beat_n == (AW+1)'(MIN_WORDS - 1));
        beat_n       <= beat_n + (AW+1)'(1);
      end
`endif
      if (pop) begin
        r_state       <= R_IDLE;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        rd_start      <= cur_end;
        desc_rd       <= desc_rd + SW'(1);
`ifdef FIFO_TX_PAD_EN
        beat_n        <= '0;
        data_done     <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fifo_tx.sv
// tb/tb_fifo_tx.sv - self-checking bench for fifo_tx
module tb_fifo_tx;
  localparam int MAX_WORDS = 380;
`ifdef FIFO_TX_PAD_EN
  localparam int             MIN_OUT  = 15;
  localparam int             T2_BEATS = 15;
  localparam logic [3:0]     T2_KEEP  = 4'hF;
`else
  localparam int             MIN_OUT  = 0;
  localparam int             T2_BEATS = 4;
  localparam logic [3:0]     T2_KEEP  = 4'h3;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        frame_drop;
  logic [3:0]  frame_count;

  int          n_tests = 0;
  int          n_fail = 0;
  int          drop_seen = 0;
  int          drops_exp = 0;
  logic [36:0] exp_q[$];
  logic        rdy_toggle = 1'b0;
  logic        rdy_level = 1'b0;
  logic        stall_q = 1'b0;
  logic [36:0] held = '0;
  logic [36:0] cmp_e;

  fifo_tx dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .frame_drop(frame_drop), .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_axis_tready = rdy_toggle ? !m_axis_tready : rdy_level;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int fid, input int i);
    return {8'(fid), 8'hC3, 16'(i)};
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Expected output of one submitted frame: dropped if too long, else its
  // words in order, optionally zero-padded up to MIN_OUT words.
  task automatic model_frame(input int len, input logic [3:0] lk, input int fid);
    int nout;
    if (len > MAX_WORDS) begin
      drops_exp++;
      return;
    end
    nout = (len < MIN_OUT) ? MIN_OUT : len;
    for (int i = 0; i < nout; i++) begin
      logic [31:0] d;
      logic [3:0]  k;
      if (i < len - 1) begin
        d = word_of(fid, i);
        k = 4'hF;
      end else if (i == len - 1) begin
        d = word_of(fid, i);
        k = lk;
        if (nout > len) begin
          d = d & mask_of(lk);
          k = 4'hF;
        end
      end else begin
        d = '0;
        k = 4'hF;
      end
      exp_q.push_back({(i == nout - 1), k, d});
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (n = 0; n < 3000; n++) begin
      @(negedge aclk);
      if (s_axis_tready) break;
    end
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL s_tready_timeout: got 0 expected 1 within 3000 cycles");
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [3:0] lk, input int fid);
    model_frame(len, lk, fid);
    for (int i = 0; i < len; i++)
      send_beat(word_of(fid, i), (i == len - 1) ? lk : 4'hF, (i == len - 1));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    if (n >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: drain timeout, got %0d beats left expected 0", tag, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_m_tdata"}, m_axis_tdata, 0);
    check({tag, "_m_tkeep"}, m_axis_tkeep, 0);
    check({tag, "_m_tlast"}, m_axis_tlast, 0);
    check({tag, "_s_tready"}, s_axis_tready, 0);
    check({tag, "_frame_drop"}, frame_drop, 0);
    check({tag, "_frame_count"}, frame_count, 0);
  endtask

  // Output scoreboard and AXIS hold-stability checker.
  always @(negedge aclk) begin
    if (areset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check("axis_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, held});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", m_axis_tdata);
        end else begin
          cmp_e = exp_q.pop_front();
          check("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, cmp_e);
        end
      end
      stall_q = m_axis_tvalid && !m_axis_tready;
      held    = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (frame_drop) drop_seen++;
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("por");
    areset = 1'b0;
    tick();
    check("tready_after_reset", s_axis_tready, 1);

    // Reset arriving with one committed frame stalled and another half written.
    rdy_level = 1'b0;
    send_frame(3, 4'h7, 1);
    send_beat(word_of(2, 0), 4'hF, 1'b0);
    send_beat(word_of(2, 1), 4'hF, 1'b0);
    check("fc_before_reset", frame_count, 1);
    areset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    check_reset_outputs("mid");
    areset = 1'b0;
    tick();
    check("fc_after_reset", frame_count, 0);
    check("tvalid_after_reset", m_axis_tvalid, 0);

    // 4-word frame: 2-cycle latency then back-to-back beats.
    rdy_level = 1'b1;
    tick();
    send_frame(4, 4'h3, 3);
    check("lat_fc", frame_count, 1);
    check("lat_tvalid0", m_axis_tvalid, 0);
    tick();
    check("lat_tvalid1", m_axis_tvalid, 0);
    tick();
    check("lat_tvalid2", m_axis_tvalid, 1);
    check("lat_first_data", m_axis_tdata, 32'h03C30000);
    for (int b = 0; b < T2_BEATS; b++) begin
      @(negedge aclk);
      check("b2b_tvalid", m_axis_tvalid, 1);
      check("b2b_tlast", m_axis_tlast, (b == T2_BEATS - 1));
      if (b == T2_BEATS - 1) check("last_tkeep", m_axis_tkeep, T2_KEEP);
    end
    @(negedge aclk);
    check("gap_tvalid", m_axis_tvalid, 0);
    tick();

    // Oversized frame is discarded whole.
    send_frame(400, 4'hF, 4);
    check("drop_pulse", frame_drop, 1);
    check("drop_fc", frame_count, 0);
    repeat (10) tick();
    check("drop_once", drop_seen, 1);
    check("drop_no_output", m_axis_tvalid, 0);
    check("drop_tready", s_axis_tready, 1);

    // Descriptor slots full: 9th frame waits until the MAC drains.
    rdy_level = 1'b0;
    tick();
    for (int f = 0; f < 8; f++) send_frame(2, 4'hF, 16 + f);
    check("full_fc", frame_count, 8);
    check("full_tready", s_axis_tready, 0);
    fork
      send_frame(2, 4'hF, 24);
      begin
        repeat (4) tick();
        check("full_hold_tready", s_axis_tready, 0);
        check("full_hold_fc", frame_count, 8);
        rdy_level = 1'b1;
      end
    join
    wait_drain("drain9", 2000);
    check("drained_fc", frame_count, 0);

    // Over 1024 words total with a toggling MAC ready: crosses the pointer wrap.
    rdy_toggle = 1'b1;
    send_frame(200, 4'h1, 30);
    send_frame(380, 4'h3, 31);
    send_frame(150, 4'h7, 32);
    send_frame(1, 4'h1, 33);
    send_frame(300, 4'hF, 34);
    send_frame(77, 4'h3, 35);
    wait_drain("wrap", 8000);
    rdy_toggle = 1'b0;
    rdy_level  = 1'b1;
    tick();

    send_frame(3, 4'h3, 36);
    wait_drain("short", 200);

    check("final_fc", frame_count, 0);
    check("final_drops", drop_seen, drops_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
